// File: rtl/sram_be_lsu_port_if.sv
// Core-side load/store handshake bundle for sram_be_lsu_port.
// The master is the core LSU; the slave is the port that turns requests into SRAM accesses.
interface sram_be_lsu_port_if #(
  parameter int BAW = 16
);
  logic           req_val;
  logic           req_rdy;
  logic           req_we;
  logic [1:0]     req_size;
  logic           req_sext;
  logic [BAW-1:0] req_addr;
  logic [31:0]    req_wdata;
  logic           rsp_val;
  logic           rsp_rdy;
  logic [31:0]    rsp_rdata;
  logic           rsp_err;

  modport master (
    output req_val, req_we, req_size, req_sext, req_addr, req_wdata, rsp_rdy,
    input  req_rdy, rsp_val, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_val, req_we, req_size, req_sext, req_addr, req_wdata, rsp_rdy,
    output req_rdy, rsp_val, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/sram_be_lsu_port.sv
// Byte-addressed load/store front-end for a 32-bit byte-enable single-port SRAM.
// One request in flight, 1-cycle response latency, full response backpressure.
module sram_be_lsu_port #(
  parameter  int DEPTH = 10234,
  localparam int AW    = $clog2(DEPTH),
  localparam int BAW   = $clog2(DEPTH) + 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  sram_be_lsu_port_if.slave   lsu,
  output logic                o_sram_en,
  output logic                o_sram_we,
  output logic [3:0]          o_sram_wbe,
  output logic [AW-1:0]       o_sram_addr,
  output logic [31:0]         o_sram_di,
  input  logic [31:0]         i_sram_do
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LIVE = 2'd1,
    HELD = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic          r_we;
  logic [1:0]    r_size;
  logic          r_sext;
  logic [1:0]    r_off;
  logic          r_err;
  logic [31:0]   r_hold;

  logic          w_acc;
  logic          w_err;
  logic [AW-1:0] w_wordAddr;
  logic [1:0]    w_off;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_rdsel;

  assign w_wordAddr = lsu.req_addr[BAW-1:2];
  assign w_off      = lsu.req_addr[1:0];

  // Extra top bit keeps the range check correct when DEPTH is a power of two.
  assign w_err = (lsu.req_size == 2'd3)
               | ((lsu.req_size == 2'd1) & w_off[0])
               | ((lsu.req_size == 2'd2) & (w_off != 2'd0))
               | ({1'b0, w_wordAddr} >= (AW+1)'(DEPTH));

  assign lsu.req_rdy = i_rst_n & (~lsu.rsp_val | lsu.rsp_rdy);
  assign w_acc       = lsu.req_val & lsu.req_rdy;

  always_comb begin
    o_sram_en   = w_acc & ~w_err;
    o_sram_we   = lsu.req_we;
    o_sram_addr = w_wordAddr;
    o_sram_di   = lsu.req_wdata;
    o_sram_wbe  = 4'b0000;
    case (lsu.req_size)
      2'd0:    o_sram_di = {4{lsu.req_wdata[7:0]}};
      2'd1:    o_sram_di = {2{lsu.req_wdata[15:0]}};
      default: o_sram_di = lsu.req_wdata;
    endcase
    if (lsu.req_we) begin
      case (lsu.req_size)
        2'd0:    o_sram_wbe = 4'b0001 << w_off;
        2'd1:    o_sram_wbe = 4'b0011 << w_off;
        default: o_sram_wbe = 4'b1111;
      endcase
    end
  end

  always_comb begin
    case (r_off)
      2'd0:    w_byte = i_sram_do[7:0];
      2'd1:    w_byte = i_sram_do[15:8];
      2'd2:    w_byte = i_sram_do[23:16];
      default: w_byte = i_sram_do[31:24];
    endcase
    w_half = r_off[1] ? i_sram_do[31:16] : i_sram_do[15:0];
    case (r_size)
      2'd0:    w_rdsel = {{24{r_sext & w_byte[7]}}, w_byte};
      2'd1:    w_rdsel = {{16{r_sext & w_half[15]}}, w_half};
      default: w_rdsel = i_sram_do;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_size  <= 2'd0;
      r_sext  <= 1'b0;
      r_off   <= 2'd0;
      r_err   <= 1'b0;
      r_hold  <= 32'd0;
    end else begin
      r_state <= w_nextState;
      if (w_acc) begin
        r_we   <= lsu.req_we;
        r_size <= lsu.req_size;
        r_sext <= lsu.req_sext;
        r_off  <= w_off;
        r_err  <= w_err;
      end
      // Snapshot the live read data; sram_do may change before the response retires.
      if (r_state == LIVE) begin
        r_hold <= lsu.rsp_rdata;
      end
    end
  end

  always_comb begin
    w_nextState   = r_state;
    lsu.rsp_val   = 1'b0;
    lsu.rsp_rdata = 32'd0;
    case (r_state)
      IDLE: begin
        if (w_acc) begin
          w_nextState = LIVE;
        end
      end
      LIVE, HELD: begin
        lsu.rsp_val = 1'b1;
        if (r_state == HELD) begin
          lsu.rsp_rdata = r_hold;
        end else if (!r_we && !r_err) begin
          lsu.rsp_rdata = w_rdsel;
        end
        if (!lsu.rsp_rdy) begin
          w_nextState = HELD;
        end else if (w_acc) begin
          w_nextState = LIVE;
        end else begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign lsu.rsp_err = lsu.rsp_val & r_err;

endmodule

// File: tb/tb_sram_be_lsu_port.sv
// Directed plus random bench for sram_be_lsu_port with a behavioural byte-enable SRAM.
// Expected responses are queued at acceptance and compared when the port presents them.
module tb_sram_be_lsu_port;
  localparam int DEPTH = 10234;
  localparam int AW    = $clog2(DEPTH);
  localparam int BAW   = $clog2(DEPTH) + 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstN;
  logic          sramEn;
  logic          sramWe;
  logic [3:0]    sramWbe;
  logic [AW-1:0] sramAddr;
  logic [31:0]   sramDi;
  logic [31:0]   sramDo;
  logic [31:0]   sramMem [0:DEPTH-1];
  logic [31:0]   refMem  [0:DEPTH-1];
  bit            memInit = 1'b0;
  logic          benchWe;
  logic [AW-1:0] benchAddr;
  logic [31:0]   benchData;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   waited;

  sram_be_lsu_port_if #(.BAW(BAW)) ifc ();

  sram_be_lsu_port #(.DEPTH(DEPTH)) dut (
    .i_clk      (clk),
    .i_rst_n    (rstN),
    .lsu        (ifc.slave),
    .o_sram_en  (sramEn),
    .o_sram_we  (sramWe),
    .o_sram_wbe (sramWbe),
    .o_sram_addr(sramAddr),
    .o_sram_di  (sramDi),
    .i_sram_do  (sramDo)
  );

  always #5 clk = ~clk;

  // Synchronous-read SRAM; the bench port lets a test overwrite a word and its read data.
  always @(posedge clk) begin
    if (!memInit) begin
      for (int i = 0; i < DEPTH; i++) sramMem[i] <= 32'd0;
      memInit <= 1'b1;
    end else if (sramEn) begin
      sramDo <= sramMem[sramAddr];
      if (sramWe) begin
        for (int b = 0; b < 4; b++) begin
          if (sramWbe[b]) sramMem[sramAddr][8*b +: 8] <= sramDi[8*b +: 8];
        end
      end
    end else if (benchWe) begin
      sramMem[benchAddr] <= benchData;
      sramDo             <= benchData;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic monitorResp();
    exp_t e;
    if (rstN && ifc.rsp_val) begin
      if (expQ.size() == 0) begin
        checkOutput("rspUnexpected", ifc.rsp_val, 1'b0);
      end else begin
        e = expQ[0];
        checkOutput("rspRdata", ifc.rsp_rdata, e.rdata);
        checkOutput("rspErr", ifc.rsp_err, e.err);
        if (ifc.rsp_rdy) begin
          void'(expQ.pop_front());
        end else begin
          checkOutput("reqRdyWhileHeld", ifc.req_rdy, 1'b0);
        end
      end
    end else if (rstN && expQ.size() > 0 && expQ[0].cyc < cyc) begin
      checkOutput("rspMissing", ifc.rsp_val, 1'b1);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idleCycles(input int n);
    ifc.req_val = 1'b0;
    repeat (n) begin
      @(negedge clk);
      monitorResp();
      stepCycle();
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sext,
                               input logic [BAW-1:0] addr, input logic [31:0] wdata,
                               input logic useConst, input logic [31:0] constRdata,
                               input logic constErr, output int nWait);
    logic          accepted;
    logic          err;
    logic [AW-1:0] wIdx;
    logic [1:0]    off;
    logic [31:0]   rd;
    logic [31:0]   lane;
    logic [3:0]    expWbe;
    logic [31:0]   expDi;
    exp_t          e;
    ifc.req_we    = we;
    ifc.req_size  = size;
    ifc.req_sext  = sext;
    ifc.req_addr  = addr;
    ifc.req_wdata = wdata;
    ifc.req_val   = 1'b1;
    accepted = 1'b0;
    nWait    = 0;
    while (!accepted && nWait < 20) begin
      @(negedge clk);
      monitorResp();
      if (ifc.req_rdy) begin
        accepted = 1'b1;
        wIdx = addr[BAW-1:2];
        off  = addr[1:0];
        err  = (size == 2'd3) || (size == 2'd1 && off[0]) || (size == 2'd2 && off != 2'd0)
               || (int'(addr[BAW-1:2]) >= DEPTH);
        rd   = 32'd0;
        checkOutput("sramEn", sramEn, !err);
        if (!err) begin
          checkOutput("sramAddr", sramAddr, wIdx);
          checkOutput("sramWe", sramWe, we);
          if (we) begin
            expWbe = (size == 2'd0) ? (4'b0001 << off) : (size == 2'd1) ? (4'b0011 << off) : 4'b1111;
            expDi  = (size == 2'd0) ? {4{wdata[7:0]}} : (size == 2'd1) ? {2{wdata[15:0]}} : wdata;
            checkOutput("sramWbe", sramWbe, expWbe);
            checkOutput("sramDi", sramDi, expDi);
            for (int b = 0; b < 4; b++) begin
              if (expWbe[b]) refMem[wIdx][8*b +: 8] = expDi[8*b +: 8];
            end
          end else begin
            checkOutput("sramWbeLoad", sramWbe, 4'b0000);
            lane = refMem[wIdx] >> (8 * off);
            case (size)
              2'd0:    rd = sext ? {{24{lane[7]}}, lane[7:0]} : {24'd0, lane[7:0]};
              2'd1:    rd = sext ? {{16{lane[15]}}, lane[15:0]} : {16'd0, lane[15:0]};
              default: rd = refMem[wIdx];
            endcase
          end
        end
        e.rdata = useConst ? constRdata : rd;
        e.err   = useConst ? constErr : err;
        e.cyc   = cyc;
        expQ.push_back(e);
      end else begin
        nWait++;
      end
      stepCycle();
    end
    if (!accepted) checkOutput("reqAcceptTimeout", ifc.req_rdy, 1'b1);
  endtask

  task automatic pulseReset();
    rstN = 1'b0;
    #1;
    checkOutput("rstRspVal", ifc.rsp_val, 1'b0);
    checkOutput("rstReqRdy", ifc.req_rdy, 1'b0);
    checkOutput("rstSramEn", sramEn, 1'b0);
    expQ.delete();
    ifc.req_val = 1'b0;
    stepCycle();
    rstN = 1'b1;
    #1;
    checkOutput("postRstReqRdy", ifc.req_rdy, 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [1:0]     rSize;
    logic [1:0]     rOff;
    logic [BAW-1:0] rAddr;
    for (int i = 0; i < DEPTH; i++) refMem[i] = 32'd0;
    rstN          = 1'b0;
    benchWe       = 1'b0;
    benchAddr     = '0;
    benchData     = 32'd0;
    ifc.rsp_rdy   = 1'b1;
    ifc.req_val   = 1'b1;
    ifc.req_we    = 1'b0;
    ifc.req_size  = 2'd2;
    ifc.req_sext  = 1'b0;
    ifc.req_addr  = '0;
    ifc.req_wdata = 32'd0;

    // Reset values with a pending request held at the inputs.
    #12;
    checkOutput("resetRspVal", ifc.rsp_val, 1'b0);
    checkOutput("resetRspErr", ifc.rsp_err, 1'b0);
    checkOutput("resetRspRdata", ifc.rsp_rdata, 32'd0);
    checkOutput("resetReqRdy", ifc.req_rdy, 1'b0);
    checkOutput("resetSramEn", sramEn, 1'b0);
    stepCycle();
    rstN        = 1'b1;
    ifc.req_val = 1'b0;
    #1;
    checkOutput("releaseReqRdy", ifc.req_rdy, 1'b1);

    // Word store then sign/zero-extended byte loads of the top byte.
    applyStimulus(1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEADBEEF, 1'b1, 32'd0, 1'b0, waited);
    applyStimulus(1'b0, 2'd0, 1'b1, 16'h0013, 32'd0, 1'b1, 32'hFFFFFFDE, 1'b0, waited);
    applyStimulus(1'b0, 2'd0, 1'b0, 16'h0013, 32'd0, 1'b1, 32'h000000DE, 1'b0, waited);
    idleCycles(2);

    // Byte store into lane 1, then a word load shows only that byte.
    applyStimulus(1'b1, 2'd0, 1'b0, 16'h0021, 32'h0000005A, 1'b1, 32'd0, 1'b0, waited);
    checkOutput("byteStoreWbe", sramWbe, 4'b0010);
    applyStimulus(1'b0, 2'd2, 1'b0, 16'h0020, 32'd0, 1'b1, 32'h00005A00, 1'b0, waited);
    idleCycles(2);

    // Held response must survive a rewrite of the same word.
    ifc.rsp_rdy = 1'b0;
    applyStimulus(1'b0, 2'd2, 1'b0, 16'h0010, 32'd0, 1'b1, 32'hDEADBEEF, 1'b0, waited);
    ifc.req_val = 1'b0;
    benchAddr   = 14'd4;
    benchData   = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      benchWe = (i == 0);
      @(negedge clk);
      monitorResp();
      stepCycle();
    end
    benchWe      = 1'b0;
    refMem[4]    = 32'h12345678;
    ifc.rsp_rdy  = 1'b1;
    idleCycles(1);
    applyStimulus(1'b0, 2'd2, 1'b0, 16'h0010, 32'd0, 1'b1, 32'h12345678, 1'b0, waited);
    idleCycles(2);

    // Error requests: misaligned half/word, illegal size, out of range.
    applyStimulus(1'b0, 2'd1, 1'b0, 16'h0003, 32'd0, 1'b1, 32'd0, 1'b1, waited);
    applyStimulus(1'b0, 2'd2, 1'b0, 16'h0002, 32'd0, 1'b1, 32'd0, 1'b1, waited);
    applyStimulus(1'b1, 2'd3, 1'b0, 16'h0000, 32'hFFFFFFFF, 1'b1, 32'd0, 1'b1, waited);
    applyStimulus(1'b0, 2'd2, 1'b0, BAW'(DEPTH * 4), 32'd0, 1'b1, 32'd0, 1'b1, waited);
    idleCycles(2);

    // Random back-to-back stream with a reset pulse in the middle.
    for (int n = 0; n < 100; n++) begin
      rSize = 2'($urandom_range(0, 2));
      rOff  = (rSize == 2'd0) ? 2'($urandom_range(0, 3)) :
              (rSize == 2'd1) ? {1'($urandom_range(0, 1)), 1'b0} : 2'd0;
      rAddr = {14'(100 + $urandom_range(0, 15)), rOff};
      applyStimulus(1'($urandom_range(0, 1)), rSize, 1'($urandom_range(0, 1)), rAddr,
                    $urandom, 1'b0, 32'd0, 1'b0, waited);
      checkOutput("streamNoStall", 32'(waited), 32'd0);
      if (n == 50) pulseReset();
    end
    idleCycles(3);
    checkOutput("streamDrained", 32'(expQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
